// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix datapath blocks
// (matmul array, dot-product units, matrix streamer and loader).
// Contents:
//   stream_state_t : two-state streaming FSM encoding
//   DEFAULT_DATA_W : default element width
//   idx_w()        : width of an index that counts 0..n-1 (minimum 1 bit)
package matmul_pkg;

   localparam int DEFAULT_DATA_W = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } stream_state_t;

   // A dimension of 1 still needs a 1-bit index so that ports never collapse to zero width.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rc_counter.sv
// Row/column index pair that walks a ROWS x COLS grid in row-major order.
// It is shared by the transmit-side streamer and the receive-side loader.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   clear_i     : force the indices back to [0][0]
//   advance_i   : step to the next element; wraps to [0][0] after the last one
//   row_o/col_o : current indices
//   col_wrap_o  : current column is COLS-1
//   last_o      : current element is [ROWS-1][COLS-1]
module rc_counter
   import matmul_pkg::*;
#(
   parameter int  ROWS = 4,
   parameter int  COLS = 4,
   localparam int RW   = idx_w(ROWS),
   localparam int CW   = idx_w(COLS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          advance_i,
   output logic [RW-1:0] row_o,
   output logic [CW-1:0] col_o,
   output logic          col_wrap_o,
   output logic          last_o
);

   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;

   assign col_wrap_o = (col_q == COL_MAX);
   assign last_o     = col_wrap_o && (row_q == ROW_MAX);
   assign row_o      = row_q;
   assign col_o      = col_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear_i || (advance_i && last_o)) begin
         row_d = '0;
         col_d = '0;
      end else if (advance_i) begin
         if (col_wrap_o) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/matrix_streamer.sv
// Snapshots a ROWS x COLS matrix on start and drains it row-major onto a
// valid/ready element stream with row-end and matrix-end markers.
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   start                : capture mat_in and begin streaming (only while idle)
//   mat_in               : source matrix, sampled on an accepted start only
//   busy                 : a matrix is being streamed
//   done                 : one-cycle pulse after the final handshake
//   m_valid / m_ready    : element handshake
//   m_data               : current element (0 while m_valid is low)
//   m_row / m_col        : indices of the current element
//   m_row_last / m_last  : end-of-row / end-of-matrix markers
//
// state  | meaning
// IDLE   | no stream in flight; start captures the matrix
// STREAM | m_valid high; each handshake advances the row/col counter
module matrix_streamer
   import matmul_pkg::*;
#(
   parameter int  ROWS   = 4,
   parameter int  COLS   = 4,
   parameter int  DATA_W = DEFAULT_DATA_W,
   localparam int RW     = idx_w(ROWS),
   localparam int CW     = idx_w(COLS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] mat_in [ROWS][COLS],
   output logic              busy,
   output logic              done,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [RW-1:0]     m_row,
   output logic [CW-1:0]     m_col,
   output logic              m_row_last,
   output logic              m_last
);

   stream_state_t     state_q, state_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] snap_q [ROWS][COLS];

   logic              capture;
   logic              handshake;
   logic [RW-1:0]     row;
   logic [CW-1:0]     col;
   logic              col_wrap;
   logic              last;

   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      capture   = 1'b0;
      handshake = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (m_ready) begin
               handshake = 1'b1;
               if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Snapshot is deliberately unreset: its contents only matter after a capture.
   always_ff @(posedge clk) begin
      if (capture) begin
         snap_q <= mat_in;
      end
   end

   rc_counter #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_rc (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (capture),
      .advance_i  (handshake),
      .row_o      (row),
      .col_o      (col),
      .col_wrap_o (col_wrap),
      .last_o     (last)
   );

   // Indices rest at [0][0] whenever idle, so only data and markers need gating.
   assign m_valid    = (state_q == STREAM);
   assign busy       = m_valid;
   assign done       = done_q;
   assign m_data     = m_valid ? snap_q[row][col] : '0;
   assign m_row      = row;
   assign m_col      = col;
   assign m_row_last = m_valid && col_wrap;
   assign m_last     = m_valid && last;

endmodule
